// File: rtl/control_fsm.sv
// Multi-cycle control unit for the 10-bit core: fetch, decode, execute, optional
// data-memory access and write-back, with a terminal HALTED state.
module control_fsm #(
   parameter logic [9:0] RESET_PC = '0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [9:0] imem_rdata,
   input  logic       imem_valid,
   output logic       imem_req,
   output logic [9:0] pc,
   output logic [2:0] alu_ctrl,
   output logic       alu_src_imm,
   output logic [9:0] imm_ext,
   input  logic [9:0] alu_result,
   input  logic       alu_halt,
   output logic [1:0] rf_ra,
   output logic [1:0] rf_rb,
   output logic [1:0] rf_wa,
   output logic       rf_we,
   output logic       rf_wsel,
   output logic       dmem_re,
   output logic       dmem_we,
   input  logic       dmem_ready,
   output logic       halted,
   output logic       instr_retired
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_HALTED
   } state_t;

   typedef struct packed {
      logic       imem_req;
      logic [2:0] alu_ctrl;
      logic       alu_src_imm;
      logic [9:0] imm_ext;
      logic [1:0] rf_ra;
      logic [1:0] rf_rb;
      logic [1:0] rf_wa;
      logic       rf_we;
      logic       rf_wsel;
      logic       dmem_re;
      logic       dmem_we;
      logic       halted;
      logic       instr_retired;
   } ctl_t;

   state_t     state_q, state_d;
   logic [9:0] ir_q, ir_d;
   logic [9:0] pc_q, pc_d;
   logic       taken_q, taken_d;
   ctl_t       ctl_q, ctl_d;

   logic [3:0] op;
   logic       is_rtype, is_addi, is_lw, is_sw, is_beq, is_jmp, is_halt;
   logic [9:0] imm_sext;
   logic       in_dp;

   // The IR is taken straight from memory on the completing fetch so the
   // registered DECODE outputs can be formed in the same cycle.
   assign ir_d = (state_q == S_FETCH && imem_valid) ? imem_rdata : ir_q;

   assign op       = ir_d[9:6];
   assign is_rtype = (op <= 4'd5);
   assign is_addi  = (op == 4'd6);
   assign is_lw    = (op == 4'd7);
   assign is_sw    = (op == 4'd8);
   assign is_beq   = (op == 4'd9);
   assign is_jmp   = (op == 4'd10);
   assign is_halt  = (op == 4'd15);
   assign imm_sext = {{8{ir_d[1]}}, ir_d[1:0]};

   always_comb begin
      state_d = state_q;
      taken_d = taken_q;
      pc_d    = pc_q;
      case (state_q)
         S_IDLE:   state_d = S_FETCH;
         S_FETCH:  if (imem_valid) state_d = S_DECODE;
         S_DECODE: state_d = S_EXEC;
         S_EXEC: begin
            taken_d = (alu_result == '0);
            if (is_lw || is_sw) begin
               state_d = S_MEM;
            end else if (is_halt) begin
               if (alu_halt) state_d = S_HALTED;
            end else begin
               state_d = S_WB;
            end
         end
         S_MEM:    if (dmem_ready) state_d = S_WB;
         S_WB: begin
            if (is_jmp) begin
               pc_d = {4'b0000, ir_d[5:0]};
            end else if (is_beq && taken_q) begin
               pc_d = pc_q + 10'd1 + imm_sext;
            end else begin
               pc_d = pc_q + 10'd1;
            end
            state_d = S_FETCH;
         end
         S_HALTED: state_d = S_HALTED;
         default:  state_d = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so that they come out of flops.
   always_comb begin
      ctl_d = '0;
      in_dp = state_d inside {S_DECODE, S_EXEC, S_MEM, S_WB};
      if (in_dp) begin
         ctl_d.rf_ra       = ir_d[5:4];
         ctl_d.rf_rb       = ir_d[3:2];
         ctl_d.alu_src_imm = is_addi || is_lw || is_sw;
         ctl_d.imm_ext     = imm_sext;
         if (is_rtype) begin
            ctl_d.alu_ctrl = op[2:0];
         end else if (is_beq) begin
            ctl_d.alu_ctrl = 3'b001;
         end else if (is_halt) begin
            ctl_d.alu_ctrl = 3'b110;
         end
      end
      ctl_d.imem_req = (state_d == S_FETCH);
      ctl_d.dmem_re  = (state_d == S_MEM) && is_lw;
      ctl_d.dmem_we  = (state_d == S_MEM) && is_sw;
      if (state_d == S_WB) begin
         ctl_d.instr_retired = 1'b1;
         ctl_d.rf_we         = is_rtype || is_addi || is_lw;
         ctl_d.rf_wsel       = is_lw;
         if (is_rtype) begin
            ctl_d.rf_wa = ir_d[1:0];
         end else if (is_addi || is_lw) begin
            ctl_d.rf_wa = ir_d[3:2];
         end
      end
      if (state_d == S_HALTED) begin
         ctl_d.halted   = 1'b1;
         ctl_d.alu_ctrl = 3'b110;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         ir_q    <= '0;
         pc_q    <= RESET_PC;
         taken_q <= 1'b0;
         ctl_q   <= '0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
         pc_q    <= pc_d;
         taken_q <= taken_d;
         ctl_q   <= ctl_d;
      end
   end

   assign imem_req      = ctl_q.imem_req;
   assign pc            = pc_q;
   assign alu_ctrl      = ctl_q.alu_ctrl;
   assign alu_src_imm   = ctl_q.alu_src_imm;
   assign imm_ext       = ctl_q.imm_ext;
   assign rf_ra         = ctl_q.rf_ra;
   assign rf_rb         = ctl_q.rf_rb;
   assign rf_wa         = ctl_q.rf_wa;
   assign rf_we         = ctl_q.rf_we;
   assign rf_wsel       = ctl_q.rf_wsel;
   assign dmem_re       = ctl_q.dmem_re;
   assign dmem_we       = ctl_q.dmem_we;
   assign halted        = ctl_q.halted;
   assign instr_retired = ctl_q.instr_retired;

endmodule
